// File: rtl/jk_reg_bank_if.sv
// Bus bundle for jk_reg_bank: control/data inputs toward the bank and
// registered state, pulses and complement back to the user.
interface jk_reg_bank_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qn;
    logic             tc;
    logic             chg;

    modport master (
        output en, mode, j, k, d,
        input  q, qn, tc, chg
    );

    modport slave (
        input  en, mode, j, k, d,
        output q, qn, tc, chg
    );
endinterface

// File: rtl/jk_reg_bank.sv
// Bank of JK flip-flops with per-bit J/K, parallel load and up/down counting
// built from synchronous toggle chains; emits terminal-count and change pulses.
module jk_reg_bank #(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] RST_VAL  = '0,
    parameter bit               SATURATE = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    jk_reg_bank_if.slave  bus
);

    typedef enum logic [1:0] {
        MODE_JK   = 2'b00,
        MODE_LOAD = 2'b01,
        MODE_UP   = 2'b10,
        MODE_DOWN = 2'b11
    } mode_t;

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] jk_nxt;
    logic [WIDTH-1:0] t_up;
    logic [WIDTH-1:0] t_dn;
    logic             run_up;
    logic             run_dn;
    logic             at_max;
    logic             at_min;
    logic             tc_nxt;
    logic             tc_r;
    logic             chg_r;
    mode_t            mode_dec;

    assign mode_dec = mode_t'(bus.mode);
    assign at_max   = &q_r;
    assign at_min   = ~|q_r;

    // Bit i toggles when every lower bit is 1 (up) or 0 (down).
    always_comb begin
        t_up   = '0;
        t_dn   = '0;
        run_up = 1'b1;
        run_dn = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            t_up[i] = run_up;
            t_dn[i] = run_dn;
            run_up  = run_up & q_r[i];
            run_dn  = run_dn & ~q_r[i];
        end
    end

    always_comb begin
        jk_nxt = q_r;
        for (int i = 0; i < WIDTH; i++) begin
            case ({bus.j[i], bus.k[i]})
                2'b00:   jk_nxt[i] = q_r[i];
                2'b01:   jk_nxt[i] = 1'b0;
                2'b10:   jk_nxt[i] = 1'b1;
                2'b11:   jk_nxt[i] = ~q_r[i];
                default: jk_nxt[i] = q_r[i];
            endcase
        end
    end

    always_comb begin
        q_nxt  = q_r;
        tc_nxt = 1'b0;
        case (mode_dec)
            MODE_JK: begin
                q_nxt = jk_nxt;
            end
            MODE_LOAD: begin
                q_nxt = bus.d;
            end
            MODE_UP: begin
                tc_nxt = at_max;
                if (!(at_max && SATURATE)) begin
                    q_nxt = q_r ^ t_up;
                end
            end
            MODE_DOWN: begin
                tc_nxt = at_min;
                if (!(at_min && SATURATE)) begin
                    q_nxt = q_r ^ t_dn;
                end
            end
            default: begin
                q_nxt = q_r;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_r   <= RST_VAL;
            tc_r  <= 1'b0;
            chg_r <= 1'b0;
        end else if (bus.en) begin
            q_r   <= q_nxt;
            tc_r  <= tc_nxt;
            chg_r <= (q_nxt != q_r);
        end else begin
            tc_r  <= 1'b0;
            chg_r <= 1'b0;
        end
    end

    assign bus.q   = q_r;
    assign bus.qn  = ~q_r;
    assign bus.tc  = tc_r;
    assign bus.chg = chg_r;

endmodule

// File: tb/tb_jk_reg_bank.sv
// Directed bench for jk_reg_bank: a wrapping instance driven from a vector
// table, plus a saturating instance exercised by hand-written sequences.
module tb_jk_reg_bank;

    localparam logic [1:0] M_JK   = 2'b00;
    localparam logic [1:0] M_LOAD = 2'b01;
    localparam logic [1:0] M_UP   = 2'b10;
    localparam logic [1:0] M_DOWN = 2'b11;

    typedef struct {
        logic       rst;
        logic       en;
        logic [1:0] mode;
        logic [7:0] j;
        logic [7:0] k;
        logic [7:0] d;
        logic [7:0] eq;
        logic       etc;
        logic       echg;
    } vec_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    vec_t vecs[$];

    jk_reg_bank_if #(.WIDTH(8)) bus0 ();
    jk_reg_bank_if #(.WIDTH(8)) bus1 ();

    jk_reg_bank #(.WIDTH(8), .RST_VAL(8'hA5), .SATURATE(1'b0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    jk_reg_bank #(.WIDTH(8), .RST_VAL(8'hA5), .SATURATE(1'b1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic r, logic e, logic [1:0] m, logic [7:0] jv,
                                logic [7:0] kv, logic [7:0] dv, logic [7:0] eqv,
                                logic etcv, logic echgv);
        vec_t v;
        v.rst = r;  v.en = e;  v.mode = m;
        v.j = jv;   v.k = kv;  v.d = dv;
        v.eq = eqv; v.etc = etcv; v.echg = echgv;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic [1:0] m,
                        input logic [7:0] jv, input logic [7:0] kv, input logic [7:0] dv);
        rst       = r;
        bus0.en   = e;  bus1.en   = e;
        bus0.mode = m;  bus1.mode = m;
        bus0.j    = jv; bus1.j    = jv;
        bus0.k    = kv; bus1.k    = kv;
        bus0.d    = dv; bus1.d    = dv;
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string name, input logic [7:0] eq, input logic etc, input logic echg);
        chk({name, "_q"},   bus1.q,          eq);
        chk({name, "_tc"},  {7'd0, bus1.tc},  {7'd0, etc});
        chk({name, "_chg"}, {7'd0, bus1.chg}, {7'd0, echg});
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus0.en = 1'b0; bus0.mode = M_JK; bus0.j = '0; bus0.k = '0; bus0.d = '0;
        bus1.en = 1'b0; bus1.mode = M_JK; bus1.j = '0; bus1.k = '0; bus1.d = '0;

        //               rst   en    mode    j      k      d      q      tc    chg
        vecs.push_back(mk(1'b1, 1'b0, M_JK,   8'h00, 8'h00, 8'h00, 8'hA5, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, M_UP,   8'h00, 8'h00, 8'h00, 8'hA5, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, M_LOAD, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 1'b1, M_JK,   8'hF0, 8'h0F, 8'h00, 8'hF0, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 1'b1, M_JK,   8'hFF, 8'hFF, 8'h00, 8'h0F, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 1'b1, M_JK,   8'h00, 8'h00, 8'h00, 8'h0F, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, M_JK,   8'h3C, 8'hC3, 8'h00, 8'h3C, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 1'b1, M_LOAD, 8'h00, 8'h00, 8'hFE, 8'hFE, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 1'b1, M_UP,   8'h00, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 1'b1, M_UP,   8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1));
        vecs.push_back(mk(1'b0, 1'b1, M_DOWN, 8'h00, 8'h00, 8'h00, 8'hFF, 1'b1, 1'b1));
        vecs.push_back(mk(1'b0, 1'b1, M_DOWN, 8'h00, 8'h00, 8'h00, 8'hFE, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 1'b1, M_LOAD, 8'h00, 8'h00, 8'h10, 8'h10, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 1'b1, M_UP,   8'h00, 8'h00, 8'h00, 8'h11, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 1'b0, M_UP,   8'h00, 8'h00, 8'h00, 8'h11, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, M_UP,   8'h00, 8'h00, 8'h00, 8'h12, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 1'b0, M_LOAD, 8'h00, 8'h00, 8'h00, 8'h12, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, M_LOAD, 8'h00, 8'h00, 8'h7F, 8'h7F, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 1'b1, M_UP,   8'h00, 8'h00, 8'h00, 8'h80, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 1'b1, M_DOWN, 8'h00, 8'h00, 8'h00, 8'h7F, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 1'b1, M_LOAD, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 1'b1, M_LOAD, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, M_LOAD, 8'h00, 8'h00, 8'h7F, 8'h7F, 1'b0, 1'b1));
        vecs.push_back(mk(1'b1, 1'b1, M_LOAD, 8'h00, 8'h00, 8'h33, 8'hA5, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, M_UP,   8'h00, 8'h00, 8'h00, 8'hA6, 1'b0, 1'b1));

        @(negedge clk);
        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].en, vecs[i].mode, vecs[i].j, vecs[i].k, vecs[i].d);
            chk($sformatf("v%0d_q", i),   bus0.q,          vecs[i].eq);
            chk($sformatf("v%0d_qn", i),  bus0.qn,         ~vecs[i].eq);
            chk($sformatf("v%0d_tc", i),  {7'd0, bus0.tc},  {7'd0, vecs[i].etc});
            chk($sformatf("v%0d_chg", i), {7'd0, bus0.chg}, {7'd0, vecs[i].echg});
        end

        // Saturating instance: holds at both limits, tc every edge, no chg.
        step(1'b1, 1'b0, M_JK, 8'h00, 8'h00, 8'h00);
        chk1("s_rst", 8'hA5, 1'b0, 1'b0);
        step(1'b0, 1'b1, M_LOAD, 8'h00, 8'h00, 8'h00);
        chk1("s_ld0", 8'h00, 1'b0, 1'b1);
        for (int n = 0; n < 3; n++) begin
            step(1'b0, 1'b1, M_DOWN, 8'h00, 8'h00, 8'h00);
            chk1($sformatf("s_dn%0d", n), 8'h00, 1'b1, 1'b0);
            if (n == 0) chk("w_dn_wrap", bus0.q, 8'hFF);
        end
        step(1'b0, 1'b1, M_LOAD, 8'h00, 8'h00, 8'hFF);
        chk1("s_ldff", 8'hFF, 1'b0, 1'b1);
        for (int n = 0; n < 2; n++) begin
            step(1'b0, 1'b1, M_UP, 8'h00, 8'h00, 8'h00);
            chk1($sformatf("s_up%0d", n), 8'hFF, 1'b1, 1'b0);
        end
        step(1'b0, 1'b0, M_UP, 8'h00, 8'h00, 8'h00);
        chk1("s_hold", 8'hFF, 1'b0, 1'b0);
        step(1'b0, 1'b1, M_LOAD, 8'h00, 8'h00, 8'h05);
        chk1("s_ld05", 8'h05, 1'b0, 1'b1);
        step(1'b0, 1'b1, M_UP, 8'h00, 8'h00, 8'h00);
        chk1("s_up05", 8'h06, 1'b0, 1'b1);
        step(1'b0, 1'b1, M_DOWN, 8'h00, 8'h00, 8'h00);
        chk1("s_dn06", 8'h05, 1'b0, 1'b1);
        step(1'b0, 1'b1, M_JK, 8'h80, 8'h01, 8'h00);
        chk1("s_jk", 8'h84, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
